// File: rtl/fp_add_sub_lzc_normalizer.sv
// Two-stage normalizer after the add/sub leading-one encoder: coarse byte shift,
// then fine bit shift, with the exponent reduced by the total shift amount.
module fp_add_sub_lzc_normalizer #(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 5,
  parameter int EXPW    = 8
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic               clk_en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   data,
  input  logic [WIDTHAD-1:0] q,
  input  logic               zero,
  input  logic [EXPW-1:0]    exp_in,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [EXPW-1:0]    exp_out,
  output logic               exp_underflow,
  output logic               result_zero
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [2:0]       fine;
    logic             zero;
    logic [EXPW:0]    diff;   // sign in MSB
  } s1_t;

  logic [WIDTHAD-1:0] shift;
  logic [WIDTHAD-1:0] coarse;
  logic               uf;

  s1_t                s1_d, s1_q;
  logic [STAGES:1]    vld_pipe_d, vld_pipe_q;
  logic [WIDTH-1:0]   result_d, result_q;
  logic [EXPW-1:0]    exp_out_d, exp_out_q;
  logic               exp_underflow_d, exp_underflow_q;
  logic               result_zero_d, result_zero_q;

  // Stage 1: shift by whole bytes; the low three shift bits ride along.
  always_comb begin
    shift     = WIDTHAD'(WIDTH - 1) - q;
    coarse    = {shift[WIDTHAD-1:3], 3'b000};
    s1_d      = '0;
    s1_d.mant = data << coarse;
    s1_d.fine = shift[2:0];
    s1_d.zero = zero;
    s1_d.diff = {1'b0, exp_in} - (EXPW + 1)'(shift);
  end

  // Stage 2: finish the shift; a non-positive exponent clamps to 0 and flags underflow.
  always_comb begin
    uf              = s1_q.diff[EXPW] || (s1_q.diff == '0);
    result_d        = s1_q.zero ? '0 : (s1_q.mant << s1_q.fine);
    exp_out_d       = (s1_q.zero || uf) ? '0 : s1_q.diff[EXPW-1:0];
    exp_underflow_d = !s1_q.zero && uf;
    result_zero_d   = s1_q.zero;
    vld_pipe_d      = {vld_pipe_q[STAGES-1:1], in_valid};
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      s1_q            <= '0;
      vld_pipe_q      <= '0;
      result_q        <= '0;
      exp_out_q       <= '0;
      exp_underflow_q <= 1'b0;
      result_zero_q   <= 1'b0;
    end else if (clk_en) begin
      s1_q            <= s1_d;
      vld_pipe_q      <= vld_pipe_d;
      result_q        <= result_d;
      exp_out_q       <= exp_out_d;
      exp_underflow_q <= exp_underflow_d;
      result_zero_q   <= result_zero_d;
    end
  end

  assign out_valid     = vld_pipe_q[STAGES];
  assign result        = result_q;
  assign exp_out       = exp_out_q;
  assign exp_underflow = exp_underflow_q;
  assign result_zero   = result_zero_q;

endmodule

// File: tb/tb_fp_add_sub_lzc_normalizer.sv
// Scoreboard bench: each issued beat queues its modelled result and the enabled-clock
// count at issue; the monitor pops on every enabled edge and checks value and latency.
module tb_fp_add_sub_lzc_normalizer;

  logic        clock = 1'b0;
  logic        aclr, clk_en, in_valid, zero;
  logic [31:0] data;
  logic [4:0]  q;
  logic [7:0]  exp_in;
  logic        out_valid, exp_underflow, result_zero;
  logic [31:0] result;
  logic [7:0]  exp_out;

  fp_add_sub_lzc_normalizer #(.WIDTH(32), .WIDTHAD(5), .EXPW(8)) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .in_valid(in_valid),
    .data(data), .q(q), .zero(zero), .exp_in(exp_in),
    .out_valid(out_valid), .result(result), .exp_out(exp_out),
    .exp_underflow(exp_underflow), .result_zero(result_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [7:0]  e;
    logic        uf;
    logic        rz;
    int          issue;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_vec = 0;
  int   n_bad = 0;
  int   en_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [4:0] qq,
                                 input logic z, input logic [7:0] e);
    exp_t m;
    int sh, diff;
    sh      = 31 - int'(qq);
    diff    = int'(e) - sh;
    m.issue = 0;
    m.rz    = z;
    if (z) begin
      m.res = 32'h0; m.e = 8'h0; m.uf = 1'b0;
    end else begin
      m.res = d << sh;
      if (diff <= 0) begin m.e = 8'h0; m.uf = 1'b1; end
      else begin m.e = diff[7:0]; m.uf = 1'b0; end
    end
    return m;
  endfunction

  function automatic logic [4:0] msb_pos(input logic [31:0] d);
    logic [4:0] p = 5'd0;
    for (int b = 0; b < 32; b++) if (d[b]) p = 5'(b);
    return p;
  endfunction

  // Monitor: every enabled edge either retires the head beat (when due) or sees no output.
  always @(posedge clock) begin
    if (clk_en && !aclr) begin
      en_cnt++;
      #1;
      if (sb.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
      else if (en_cnt - sb[0].issue >= 2) begin
        last = sb.pop_front();
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("result", 64'(result), 64'(last.res));
        chk("exp_out", 64'(exp_out), 64'(last.e));
        chk("exp_underflow", 64'(exp_underflow), 64'(last.uf));
        chk("result_zero", 64'(result_zero), 64'(last.rz));
      end else chk("early_valid", 64'(out_valid), 64'd0);
    end
  end

  task automatic beat(input logic [31:0] d, input logic [4:0] qq, input logic z, input logic [7:0] e);
    exp_t m;
    @(negedge clock);
    clk_en = 1'b1; in_valid = 1'b1; data = d; q = qq; zero = z; exp_in = e;
    m = model(d, qq, z, e);
    m.issue = en_cnt;
    sb.push_back(m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      clk_en = 1'b1; in_valid = 1'b0; data = $urandom; q = 5'($urandom);
      zero = 1'b0; exp_in = 8'($urandom);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {31'd0, out_valid, result, exp_out, exp_underflow, result_zero}, 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  qq;
    logic        z;
    aclr = 1'b1; clk_en = 1'b1; in_valid = 1'b0; data = '0; q = '0; zero = 1'b0; exp_in = '0;
    #1 chk_all_zero("reset_state");
    repeat (2) @(negedge clock);
    aclr = 1'b0;

    // Directed vectors
    beat(32'h0000_0001, 5'd0, 1'b0, 8'd40);
    idle(3);
    beat(32'h8000_0000, 5'd31, 1'b0, 8'd127);
    beat(32'h0001_2345, 5'd16, 1'b0, 8'd100);
    beat(32'h0000_0000, 5'd9,  1'b1, 8'd50);
    beat(32'h0000_00FF, 5'd7,  1'b0, 8'd24);
    beat(32'h0000_00FF, 5'd7,  1'b0, 8'd25);
    beat(32'hF000_000F, 5'd3,  1'b0, 8'd200);
    beat(32'h0000_0001, 5'd0,  1'b0, 8'd0);
    idle(3);

    // Stall: A emerges, B held in stage 1 while inputs churn with clk_en low
    beat(32'h0000_0C00, 5'd11, 1'b0, 8'd90);
    beat(32'h0003_0000, 5'd17, 1'b0, 8'd60);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_frozen", {21'd0, out_valid, result, exp_out, exp_underflow, result_zero},
          {21'd0, 1'b1, last.res, last.e, last.uf, last.rz});
      clk_en = 1'b0; in_valid = 1'b1; data = $urandom | 32'h1; q = 5'($urandom);
      zero = 1'b0; exp_in = 8'($urandom);
    end
    idle(4);

    // Reset with beats in flight
    beat(32'h0000_1234, 5'd12, 1'b0, 8'd70);
    beat(32'h0040_0000, 5'd22, 1'b0, 8'd80);
    @(negedge clock);
    in_valid = 1'b0;
    aclr = 1'b1;
    #1 chk_all_zero("async_clear");
    sb.delete();
    #2 aclr = 1'b0;
    idle(4);
    beat(32'h0000_0100, 5'd8, 1'b0, 8'd30);
    idle(4);

    // Random back-to-back traffic with occasional bubbles
    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      if (i % 5 == 0) d = d >> $urandom_range(31, 0);
      z = (d == 32'h0) || (i % 7 == 3);
      if (z) d = 32'h0;
      qq = z ? 5'($urandom) : msb_pos(d);
      beat(d, qq, z, 8'($urandom_range(0, 255)));
      if (i % 6 == 5) idle(1);
    end
    idle(4);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
